// File: rtl/change_hopper_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : change_hopper_arbiter
// Brief   : Round-robin change-request arbiter driving a single 25/10/5 coin
//           hopper one coin at a time, with per-denomination inventory/refill.
// Rev     : 1.0 - initial release
// ============================================================================
module change_hopper_arbiter #(
    parameter int N_REQ       = 3,
    parameter int AMT_W       = 7,
    parameter int CNT_W       = 8,
    parameter int COIN_CYCLES = 4,
    parameter int INIT_Q      = 20,
    parameter int INIT_D      = 20,
    parameter int INIT_N      = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*AMT_W-1:0]   req_amount,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         done,
    output logic [AMT_W-1:0]         shortfall,
    output logic                     hopper_en,
    output logic [1:0]               hopper_type,
    input  logic                     refill_en,
    input  logic [1:0]               refill_type,
    input  logic [CNT_W-1:0]         refill_count,
    output logic [CNT_W-1:0]         stock_q,
    output logic [CNT_W-1:0]         stock_d,
    output logic [CNT_W-1:0]         stock_n,
    output logic                     busy
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CYC_W = (COIN_CYCLES > 1) ? $clog2(COIN_CYCLES) : 1;

    localparam logic [1:0]       c_NONE    = 2'b00;
    localparam logic [1:0]       c_NICKEL  = 2'b01;
    localparam logic [1:0]       c_DIME    = 2'b10;
    localparam logic [1:0]       c_QUARTER = 2'b11;
    localparam logic [AMT_W-1:0] c_V5      = AMT_W'(5);
    localparam logic [AMT_W-1:0] c_V10     = AMT_W'(10);
    localparam logic [AMT_W-1:0] c_V25     = AMT_W'(25);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SELECT = 3'd1,
        S_PAY    = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_id;
    logic [AMT_W-1:0]   r_rem;
    logic [AMT_W-1:0]   r_frac;
    logic [1:0]         r_type;
    logic [CYC_W-1:0]   r_cyc;
    logic [CNT_W-1:0]   r_stock_q;
    logic [CNT_W-1:0]   r_stock_d;
    logic [CNT_W-1:0]   r_stock_n;

    logic               w_found;
    logic [PTR_W-1:0]   w_gnt;
    logic [AMT_W-1:0]   w_amt;
    logic [AMT_W-1:0]   w_frac;
    logic [1:0]         w_pick;
    logic [AMT_W-1:0]   w_coin_val;

    // First requester at or after the RR pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && req_valid[i] && (i == ((int'(r_ptr) + k) % N_REQ))) begin
                    w_found = 1'b1;
                    w_gnt   = PTR_W'(i);
                end
            end
        end
        w_amt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt == PTR_W'(i)) begin
                w_amt = req_amount[i*AMT_W +: AMT_W];
            end
        end
    end

    assign w_frac = w_amt % c_V5;

    // Greedy pick: largest coin that fits the remainder and is in stock.
    always_comb begin
        w_pick     = c_NONE;
        w_coin_val = '0;
        if (r_rem >= c_V25 && r_stock_q != '0) begin
            w_pick     = c_QUARTER;
            w_coin_val = c_V25;
        end else if (r_rem >= c_V10 && r_stock_d != '0) begin
            w_pick     = c_DIME;
            w_coin_val = c_V10;
        end else if (r_rem >= c_V5 && r_stock_n != '0) begin
            w_pick     = c_NICKEL;
            w_coin_val = c_V5;
        end
    end

    function automatic logic [CNT_W-1:0] f_stock_next(
        input logic [CNT_W-1:0] cur,
        input logic             dec,
        input logic             add,
        input logic [CNT_W-1:0] cnt
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, cur} - {{CNT_W{1'b0}}, dec} + (add ? {1'b0, cnt} : {(CNT_W+1){1'b0}});
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    logic w_sel;
    assign w_sel = (r_state == S_SELECT);

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        done        = '0;
        shortfall   = '0;
        hopper_en   = 1'b0;
        hopper_type = c_NONE;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    for (int i = 0; i < N_REQ; i++) begin
                        if (w_gnt == PTR_W'(i)) req_ready[i] = 1'b1;
                    end
                    w_state_nxt = S_SELECT;
                end
            end
            S_SELECT: w_state_nxt = (w_pick == c_NONE) ? S_DONE : S_PAY;
            S_PAY: begin
                hopper_en   = 1'b1;
                hopper_type = r_type;
                if (r_cyc == CYC_W'(COIN_CYCLES - 1)) w_state_nxt = S_GAP;
            end
            S_GAP: w_state_nxt = S_SELECT;
            S_DONE: begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (r_id == PTR_W'(i)) done[i] = 1'b1;
                end
                shortfall   = r_rem + r_frac;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_rem     <= '0;
            r_frac    <= '0;
            r_type    <= c_NONE;
            r_cyc     <= '0;
            r_stock_q <= CNT_W'(INIT_Q);
            r_stock_d <= CNT_W'(INIT_D);
            r_stock_n <= CNT_W'(INIT_N);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_id   <= w_gnt;
                        r_rem  <= w_amt - w_frac;
                        r_frac <= w_frac;
                    end
                end
                S_SELECT: begin
                    if (w_pick != c_NONE) begin
                        r_rem  <= r_rem - w_coin_val;
                        r_type <= w_pick;
                        r_cyc  <= '0;
                    end
                end
                S_PAY:  r_cyc <= r_cyc + CYC_W'(1);
                S_DONE: r_ptr <= (r_id == PTR_W'(N_REQ - 1)) ? '0 : r_id + PTR_W'(1);
                default: ;
            endcase
            // Refill and greedy decrement may land on the same counter together.
            r_stock_q <= f_stock_next(r_stock_q, w_sel && (w_pick == c_QUARTER),
                                      refill_en && (refill_type == c_QUARTER), refill_count);
            r_stock_d <= f_stock_next(r_stock_d, w_sel && (w_pick == c_DIME),
                                      refill_en && (refill_type == c_DIME), refill_count);
            r_stock_n <= f_stock_next(r_stock_n, w_sel && (w_pick == c_NICKEL),
                                      refill_en && (refill_type == c_NICKEL), refill_count);
        end
    end

    assign stock_q = r_stock_q;
    assign stock_d = r_stock_d;
    assign stock_n = r_stock_n;

endmodule
`default_nettype wire

// File: tb/tb_change_hopper_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_change_hopper_arbiter
// Brief   : Self-checking bench: directed table, hand sequences, random requests.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_change_hopper_arbiter;

    localparam int N_REQ       = 3;
    localparam int AMT_W       = 7;
    localparam int CNT_W       = 8;
    localparam int COIN_CYCLES = 4;
    localparam int INIT        = 20;
    localparam int PER_COIN    = COIN_CYCLES + 2;
    localparam int SMAX        = 255;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*AMT_W-1:0] req_amount;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       done;
    logic [AMT_W-1:0]       shortfall;
    logic                   hopper_en;
    logic [1:0]             hopper_type;
    logic                   refill_en;
    logic [1:0]             refill_type;
    logic [CNT_W-1:0]       refill_count;
    logic [CNT_W-1:0]       stock_q, stock_d, stock_n;
    logic                   busy;

    always #5 clk = ~clk;

    change_hopper_arbiter #(
        .N_REQ(N_REQ), .AMT_W(AMT_W), .CNT_W(CNT_W), .COIN_CYCLES(COIN_CYCLES),
        .INIT_Q(INIT), .INIT_D(INIT), .INIT_N(INIT)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(req_ready), .done(done), .shortfall(shortfall),
        .hopper_en(hopper_en), .hopper_type(hopper_type),
        .refill_en(refill_en), .refill_type(refill_type), .refill_count(refill_count),
        .stock_q(stock_q), .stock_d(stock_d), .stock_n(stock_n), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: stock per denomination (0=quarter,1=dime,2=nickel).
    int m_stk[3];
    int m_val[3]  = '{25, 10, 5};
    int m_type[3] = '{3, 2, 1};
    int m_coins[$];
    int m_sf;
    int m_ptr;

    typedef struct {
        int idx; int amt; int rf_t; int rf_c;
        int exp_sf; int exp_q; int exp_d; int exp_n;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_refill(input int t, input int c);
        int i;
        if (t != 0) begin
            i = 3 - t;
            m_stk[i] = (m_stk[i] + c > SMAX) ? SMAX : m_stk[i] + c;
        end
    endtask

    task automatic model_pay(input int amt);
        int rem;
        int pick;
        rem = (amt / 5) * 5;
        m_coins.delete();
        pick = 0;
        while (pick >= 0) begin
            pick = -1;
            for (int i = 0; i < 3; i++)
                if (pick < 0 && m_val[i] <= rem && m_stk[i] > 0) pick = i;
            if (pick >= 0) begin
                rem = rem - m_val[pick];
                m_stk[pick] = m_stk[pick] - 1;
                m_coins.push_back(m_type[pick]);
            end
        end
        m_sf = rem + amt % 5;
    endtask

    task automatic check_stock(input string name, input int q, input int d, input int n);
        check({name, "_q"}, int'(stock_q), q);
        check({name, "_d"}, int'(stock_d), d);
        check({name, "_n"}, int'(stock_n), n);
    endtask

    task automatic refill_once(input int t, input int c);
        refill_en    = 1'b1;
        refill_type  = 2'(t);
        refill_count = 8'(c);
        tick();
        refill_en = 1'b0;
        model_refill(t, c);
    endtask

    // Single request; optional refill driven during relative cycle rf_cyc.
    task automatic do_req(input int idx, input int amt, input int rf_cyc,
                          input int rf_t, input int rf_c, output int sf_obs);
        int k, exp_done, bad, dcyc, dval, j, p, exp_en, exp_t;
        bit got;
        model_pay(amt);
        k = m_coins.size();
        exp_done = 2 + PER_COIN * k;
        req_amount = '0;
        req_amount[idx*AMT_W +: AMT_W] = 7'(amt);
        req_valid = 3'(1 << idx);
        @(negedge clk);
        check("ready", int'(req_ready), 1 << idx);
        tick();
        req_valid = '0;
        bad = 0; got = 0; dcyc = -1; dval = 0; sf_obs = -1;
        for (int c = 1; c <= exp_done + 4 && !got; c++) begin
            if (c == rf_cyc) begin
                refill_en    = 1'b1;
                refill_type  = 2'(rf_t);
                refill_count = 8'(rf_c);
            end
            @(negedge clk);
            j = (c - 1) / PER_COIN;
            p = (c - 1) % PER_COIN;
            exp_en = (j < k && p >= 1 && p <= COIN_CYCLES) ? 1 : 0;
            exp_t  = (exp_en == 1) ? m_coins[j] : 0;
            if (int'(hopper_en) != exp_en || int'(hopper_type) != exp_t || busy != 1'b1) bad++;
            if (done != '0) begin
                got = 1; dcyc = c; dval = int'(done); sf_obs = int'(shortfall);
            end
            tick();
            refill_en = 1'b0;
        end
        if (rf_cyc > 0) model_refill(rf_t, rf_c);
        check("trace", bad, 0);
        check("done_cycle", dcyc, exp_done);
        check("done_id", dval, 1 << idx);
        m_ptr = (idx + 1) % N_REQ;
    endtask

    // Several requesters of 5 cents held together; compare grant order with the model.
    task automatic rr_burst(input logic [2:0] mask, input string name, output int first);
        int exp_order[$];
        int got_order[$];
        logic [2:0] pend, rdy;
        int g, ndone, bad, mism;
        pend = mask;
        while (pend != 0) begin
            g = -1;
            for (int k = 0; k < 3; k++)
                if (g < 0 && pend[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            exp_order.push_back(g);
            pend[g] = 1'b0;
            model_pay(5);
            m_ptr = (g + 1) % 3;
        end
        req_amount = {3{7'd5}};
        req_valid  = mask;
        ndone = 0; bad = 0;
        for (int cyc = 0; cyc < 400 && ndone < $countones(mask); cyc++) begin
            @(negedge clk);
            rdy = req_ready;
            if (rdy != '0) begin
                g = -1;
                for (int i = 0; i < 3; i++) if (rdy[i]) g = (g < 0) ? i : 99;
                got_order.push_back(g);
            end
            if (done != '0) begin
                ndone++;
                if (shortfall != '0) bad++;
            end
            tick();
            req_valid = req_valid & ~rdy;
        end
        req_valid = '0;
        mism = (got_order.size() == exp_order.size()) ? 0 : 1;
        for (int i = 0; i < exp_order.size() && i < got_order.size(); i++)
            if (got_order[i] != exp_order[i]) mism++;
        check({name, "_order"}, mism, 0);
        check({name, "_done_sf"}, bad, 0);
        first = (got_order.size() > 0) ? got_order[0] : -1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sf, first, bad, seen;
        rst = 1'b1; req_valid = '0; req_amount = '0;
        refill_en = 1'b0; refill_type = '0; refill_count = '0;
        m_stk = '{INIT, INIT, INIT}; m_ptr = 0;

        //          idx amt rf_t rf_c  sf  q   d   n
        tbl[0]  = '{0,  65, 0,   0,    0,  18, 19, 19};
        tbl[1]  = '{1,  7,  0,   0,    2,  18, 19, 18};
        tbl[2]  = '{2,  0,  0,   0,    0,  18, 19, 18};
        tbl[3]  = '{0,  125,0,   0,    0,  13, 19, 18};
        tbl[4]  = '{1,  125,0,   0,    0,  8,  19, 18};
        tbl[5]  = '{2,  125,0,   0,    0,  3,  19, 18};
        tbl[6]  = '{0,  125,0,   0,    0,  0,  14, 18};
        tbl[7]  = '{1,  120,0,   0,    0,  0,  2,  18};
        tbl[8]  = '{2,  100,0,   0,    0,  0,  0,  2};
        tbl[9]  = '{0,  15, 0,   0,    5,  0,  0,  0};
        tbl[10] = '{1,  30, 2,   1,    20, 0,  0,  0};
        tbl[11] = '{2,  0,  1,   254,  0,  0,  0,  254};
        tbl[12] = '{0,  0,  1,   5,    0,  0,  0,  255};
        tbl[13] = '{1,  5,  0,   50,   0,  0,  0,  254};

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(req_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_hopper_en", int'(hopper_en), 0);
        check("rst_hopper_type", int'(hopper_type), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_shortfall", int'(shortfall), 0);
        check_stock("rst_stock", INIT, INIT, INIT);
        rst = 1'b0;
        tick();

        for (int r = 0; r < 14; r++) begin
            if (tbl[r].rf_t != 0 || tbl[r].rf_c != 0) refill_once(tbl[r].rf_t, tbl[r].rf_c);
            do_req(tbl[r].idx, tbl[r].amt, -1, 0, 0, sf);
            check($sformatf("row%0d_sf", r), sf, tbl[r].exp_sf);
            check_stock($sformatf("row%0d", r), tbl[r].exp_q, tbl[r].exp_d, tbl[r].exp_n);
        end

        // Round-robin: pointer to 0, then two full bursts, then pointer=1 with {0,2}.
        do_req(2, 0, -1, 0, 0, sf);
        rr_burst(3'b111, "rr_all_a", first);
        check("rr_all_a_first", first, 0);
        rr_burst(3'b111, "rr_all_b", first);
        check("rr_all_b_first", first, 0);
        do_req(0, 0, -1, 0, 0, sf);
        rr_burst(3'b101, "rr_ptr1", first);
        check("rr_ptr1_first", first, 2);
        check_stock("rr_stock", m_stk[0], m_stk[1], m_stk[2]);

        // Reset asserted during the second PAY cycle.
        req_amount = '0;
        req_amount[1*AMT_W +: AMT_W] = 7'd65;
        req_valid = 3'b010;
        @(negedge clk);
        tick();
        req_valid = '0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (hopper_en) seen = 1;
            tick();
        end
        check("midpay_hopper_on", int'(hopper_en) & seen, 1);
        #2;
        rst = 1'b1;
        #1;
        check("midpay_hopper_off", int'(hopper_en), 0);
        check("midpay_busy", int'(busy), 0);
        check_stock("midpay_stock", INIT, INIT, INIT);
        tick();
        rst = 1'b0;
        m_stk = '{INIT, INIT, INIT}; m_ptr = 0;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done != '0 || hopper_en) bad++;
            tick();
        end
        check("midpay_no_done", bad, 0);
        do_req(2, 65, -1, 0, 0, sf);
        check("post_rst_sf", sf, 0);
        check_stock("post_rst", 18, 19, 19);

        // Drain nickels to 10, then refill in the SELECT cycle and during PAY.
        for (int i = 0; i < 9; i++) do_req(i % 3, 5, -1, 0, 0, sf);
        check("drain_n", int'(stock_n), 10);
        do_req(0, 5, 1, 1, 3, sf);
        check("sel_refill_n", int'(stock_n), 12);
        do_req(1, 5, 3, 1, 2, sf);
        check("pay_refill_n", int'(stock_n), 13);

        for (int it = 0; it < 20; it++) begin
            if ($urandom_range(0, 1) == 1)
                refill_once(int'($urandom_range(0, 3)), int'($urandom_range(0, 60)));
            do_req(int'($urandom_range(0, 2)), int'($urandom_range(0, 127)), -1, 0, 0, sf);
            check($sformatf("rnd%0d_sf", it), sf, m_sf);
            check_stock($sformatf("rnd%0d", it), m_stk[0], m_stk[1], m_stk[2]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/change_hopper_arbiter.md
Name: change_hopper_arbiter

Overview:
- Shared coin-payout controller for a bank of vending-machine front-ends that all need to return change.
- Accepts change requests from N_REQ requesters and grants them round-robin.
- Drives a single coin hopper (25/10/5) one coin at a time, tracking per-denomination coin inventory.
- Reports completion or shortfall back to the granted requester, and accepts refill commands from the service port.

Parameters:
N_REQ, 3, number of requesters
AMT_W, 7, change amount width (cents)
CNT_W, 8, coin inventory counter width per denomination
COIN_CYCLES, 4, cycles hopper_en is held per coin
INIT_Q, 20, reset quarter count
INIT_D, 20, reset dime count
INIT_N, 20, reset nickel count

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid  in  N_REQ  per-requester change request, held until req_ready
req_amount  in  N_REQ*AMT_W  packed amounts, requester i at [i*AMT_W +: AMT_W]
req_ready  out  N_REQ  one-hot acceptance pulse
done  out  N_REQ  one-hot completion pulse to the granted requester
shortfall  out  AMT_W  unpaid cents, valid while any done bit is high
hopper_en  out  1  hopper motor drive
hopper_type  out  2  00=none, 01=5, 10=10, 11=25
refill_en  in  1  refill command
refill_type  in  2  denomination to refill, same encoding; 00 is ignored
refill_count  in  CNT_W  coins added
stock_q, stock_d, stock_n  out  CNT_W each  current inventory
busy  out  1  high in every state except IDLE

Behaviour:
- Reset values:
  - state=IDLE; all outputs 0 except the stock counters.
  - stock_q/d/n = INIT_Q/D/N.
  - RR pointer = 0.
  - hopper_en drops immediately on rst (asynchronous); any in-flight request is discarded with no done pulse.
- States: IDLE, SELECT, PAY, GAP, DONE.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from the RR pointer upward, with wrap.
  - req_ready[g]=1 in that same cycle (Mealy).
  - Latch id=g and rem = amount rounded down to a multiple of 5; latch frac = amount mod 5.
  - Next state is SELECT.
- SELECT (one cycle, hopper idle):
  - If rem==0, go to DONE.
  - Otherwise choose the largest coin c with c ≤ rem and stock(c) > 0.
  - If no such coin exists, go to DONE (shortfall).
  - If a coin is chosen: rem -= c, stock(c) -= 1, latch the type, go to PAY.
- PAY:
  - hopper_en=1 and hopper_type=latched type for exactly COIN_CYCLES consecutive cycles, then go to GAP.
- GAP:
  - One idle cycle with hopper_en=0, then back to SELECT.
- DONE (one cycle):
  - done[id]=1 and shortfall = rem + frac.
  - RR pointer = (id+1) mod N_REQ.
  - Next state is IDLE.
- Latency:
  - Per coin: 1 + COIN_CYCLES + 1 cycles.
  - Request with k coins: acceptance cycle, then k*(COIN_CYCLES+2), then SELECT, then DONE.
- Requests:
  - Only one request is in service at a time.
  - Other req_valid bits wait; they are not dropped.
  - req_amount is sampled only in the acceptance cycle.
- Refill:
  - Applied in any state.
  - stock += refill_count, saturating at 2^CNT_W-1.
  - If a refill and a SELECT decrement hit the same denomination in the same cycle, the result is stock - 1 + refill_count, saturated.
  - A refill on a denomination never disturbs the coin already latched for payout.
- Greedy decisions are made per coin using current stock. No lookahead: a refill arriving mid-payout is usable from the next SELECT.
- Amount 0: accept, then SELECT, then DONE with shortfall=0 and no hopper activity.

Test Plan:
- Single request: req 0 for 65, full stock → hopper types 11,11,10,01, each 4 cycles with a 1-cycle gap; done[0] with shortfall=0; stock_q=18, stock_d=19, stock_n=19; done exactly 26 cycles after acceptance.
- Round-robin: all three requesters assert 5 simultaneously → grant order 0,1,2; re-assert all → order 0,1,2 again; with pointer=1 and req {0,2} → grant 2 first.
- Shortage: stock_q=0, stock_d=1, stock_n=0, req 30 → one dime dispensed; done with shortfall=20; stock_d=0.
- Fractional amount: req 7 → one nickel; shortfall=2.
- Refill: stock_n=254 plus refill 5 → saturates at 255; refill of nickels in the same cycle as a SELECT nickel decrement from 10 with count 3 → 12.
- Reset mid-PAY: rst asserted in the 2nd PAY cycle → hopper_en=0 immediately; stock back to INIT values; no done pulse; a new request is then serviced normally.
